// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame transmitter.
// Contents: baud divisor constants (bit time = DIV+1 clocks at 50 MHz), the header and
// trailer bytes, the last byte index of a frame, and the frame/byte FSM state encodings.
// Optional feature macro: FRAME_CHECKSUM_EN (inserts an XOR checksum byte before the trailer).
package uart_pkg;

    localparam int unsigned CntW = 13;

    localparam logic [CntW-1:0] Div9600   = 13'd5207;
    localparam logic [CntW-1:0] Div19200  = 13'd2603;
    localparam logic [CntW-1:0] Div38400  = 13'd1301;
    localparam logic [CntW-1:0] Div57600  = 13'd867;
    localparam logic [CntW-1:0] Div115200 = 13'd433;

    localparam logic [7:0] HdrByte0    = 8'hFF;
    localparam logic [7:0] HdrByte1    = 8'hA5;
    localparam logic [7:0] TrailerByte = 8'hF0;

`ifdef FRAME_CHECKSUM_EN
    localparam logic [2:0] LastByteIdx = 3'd6;
`else
    localparam logic [2:0] LastByteIdx = 3'd5;
`endif

    typedef enum logic [1:0] {
        FrmIdle,
        FrmSend,
        FrmDone
    } frame_state_e;

    typedef enum logic [1:0] {
        ByteIdle,
        ByteStart,
        ByteData,
        ByteStop
    } byte_state_e;

    // Codes 5..7 fall back to the fastest rate.
    function automatic logic [CntW-1:0] baud_div(input logic [2:0] baud_set);
        case (baud_set)
            3'd0:    baud_div = Div9600;
            3'd1:    baud_div = Div19200;
            3'd2:    baud_div = Div38400;
            3'd3:    baud_div = Div57600;
            default: baud_div = Div115200;
        endcase
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Byte serializer: sends one 8N1 character (start 0, data LSB first, stop 1), each bit
// held for div_i+1 clocks.
// Ports:
//   clk_i, rst_ni  - clock, asynchronous active-low reset
//   start_i        - launch a byte; sampled in idle, or on the last cycle of a stop bit
//   data_i         - byte to send, captured together with start_i
//   div_i          - bit-time divisor, must stay stable while busy
//   tx_o           - serial line, idle high
//   busy_o         - a character is on the line
//   done_o         - last cycle of the stop bit
module uart_byte_tx
    import uart_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [7:0]      data_i,
    input  logic [CntW-1:0] div_i,
    output logic            tx_o,
    output logic            busy_o,
    output logic            done_o
);

    byte_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            bit_end;

    assign bit_end = (cnt_q == div_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ByteIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        done_o  = 1'b0;
        unique case (state_q)
            ByteIdle: begin
                if (start_i) begin
                    state_d = ByteStart;
                    cnt_d   = '0;
                    bit_d   = '0;
                    data_d  = data_i;
                end
            end
            ByteStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = ByteData;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            ByteData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = ByteStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            ByteStop: begin
                if (bit_end) begin
                    cnt_d  = '0;
                    done_o = 1'b1;
                    // Chain straight into the next start bit so bytes are back to back.
                    if (start_i) begin
                        state_d = ByteStart;
                        bit_d   = '0;
                        data_d  = data_i;
                    end else begin
                        state_d = ByteIdle;
                    end
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            default: state_d = ByteIdle;
        endcase
    end

    always_comb begin
        tx_o = 1'b1;
        unique case (state_q)
            ByteStart: tx_o = 1'b0;
            ByteData:  tx_o = data_q[bit_q];
            default:   tx_o = 1'b1;
        endcase
    end

    assign busy_o = (state_q != ByteIdle);

endmodule

// File: rtl/uart_frame_tx.sv
// Time-stamp frame transmitter: on Send_Go sends FF A5 Hour Minute Second F0 as
// back-to-back 8N1 characters at the selected baud rate.
// Optional feature macro: FRAME_CHECKSUM_EN adds a checksum byte (Hour^Minute^Second)
// between Second and the F0 trailer.
// Ports:
//   Clk, Reset_n          - 50 MHz clock, asynchronous active-low reset
//   Baud_Set              - 0=9600 1=19200 2=38400 3=57600 4..7=115200
//   Send_Go               - one-cycle frame request, honoured only when idle
//   Hour, Minute, Second  - BCD payload, captured when the request is accepted
//   uart_tx               - serial line, idle high
//   Busy                  - first start bit through last stop bit
//   Frame_Done            - one-cycle pulse after the last stop bit
module uart_frame_tx
    import uart_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] Baud_Set,
    input  logic       Send_Go,
    input  logic [7:0] Hour,
    input  logic [7:0] Minute,
    input  logic [7:0] Second,
    output logic       uart_tx,
    output logic       Busy,
    output logic       Frame_Done
);

    frame_state_e    state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      hour_q, hour_d;
    logic [7:0]      minute_q, minute_d;
    logic [7:0]      second_q, second_d;
    logic [2:0]      baud_q, baud_d;

    logic            byte_start;
    logic [7:0]      byte_data;
    logic [CntW-1:0] byte_div;
    logic            byte_busy;
    logic            byte_done;

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [7:0] h,
                                              input logic [7:0] m, input logic [7:0] s);
        case (idx)
            3'd0:    frame_byte = HdrByte0;
            3'd1:    frame_byte = HdrByte1;
            3'd2:    frame_byte = h;
            3'd3:    frame_byte = m;
            3'd4:    frame_byte = s;
`ifdef FRAME_CHECKSUM_EN
            3'd5:    frame_byte = h ^ m ^ s;
`endif
            default: frame_byte = TrailerByte;
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q  <= FrmIdle;
            idx_q    <= '0;
            hour_q   <= '0;
            minute_q <= '0;
            second_q <= '0;
            baud_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hour_q   <= hour_d;
            minute_q <= minute_d;
            second_q <= second_d;
            baud_q   <= baud_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        hour_d     = hour_q;
        minute_d   = minute_q;
        second_d   = second_q;
        baud_d     = baud_q;
        byte_start = 1'b0;
        unique case (state_q)
            FrmIdle: begin
                if (Send_Go) begin
                    state_d  = FrmSend;
                    idx_d    = '0;
                    hour_d   = Hour;
                    minute_d = Minute;
                    second_d = Second;
                    baud_d   = Baud_Set;
                end
            end
            FrmSend: begin
                // The serializer is only idle on the first SEND cycle; afterwards each
                // byte is launched on the stop-bit end of the previous one.
                if (!byte_busy) begin
                    byte_start = 1'b1;
                end else if (byte_done) begin
                    if (idx_q == LastByteIdx) begin
                        state_d = FrmDone;
                    end else begin
                        idx_d      = idx_q + 3'd1;
                        byte_start = 1'b1;
                    end
                end
            end
            FrmDone: state_d = FrmIdle;
            default: state_d = FrmIdle;
        endcase
    end

    // idx_d already points at the byte being launched when chaining.
    assign byte_data = frame_byte(idx_d, hour_q, minute_q, second_q);
    assign byte_div  = baud_div(baud_q);

    uart_byte_tx u_byte_tx (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .start_i (byte_start),
        .data_i  (byte_data),
        .div_i   (byte_div),
        .tx_o    (uart_tx),
        .busy_o  (byte_busy),
        .done_o  (byte_done)
    );

    assign Busy       = (state_q == FrmSend) && byte_busy;
    assign Frame_Done = (state_q == FrmDone);

endmodule
